// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath:
// decode inputs (enable, opcode, zero) and every mux select / write strobe.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [5:0]       opcode;
    logic             zero;
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    // Datapath / board side: drives enable and decode inputs, observes controls.
    modport master (
        output enable, opcode, zero,
        input  pc_en, pc_source, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, state, illegal_op, instr_count
    );

    // Controller side.
    modport slave (
        input  enable, opcode, zero,
        output pc_en, pc_source, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, state, illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Moore decode of the registered state drives
// all datapath selects; write strobes are gated by enable and reset so that
// switch-stepping and mid-instruction reset never produce stray writes.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_illegal;
    logic             w_gate;
    logic             w_pc_write;
    logic             w_pc_write_cond;
    logic [1:0]       w_pc_source;
    logic             w_iord;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_reg_dst;
    logic             w_mem_to_reg;
    logic             w_reg_write;
    logic             w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_alu_op;

    // State register: advances only on enabled edges, async reset to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else if (bus.enable) begin
            r_state <= w_next;
        end else begin
            r_state <= r_state;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR.
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW) begin
                    w_next = S_MEM_READ;
                end else begin
                    w_next = S_MEM_WRITE;
                end
            end
            S_MEM_READ:  w_next = S_MEM_WB;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = S_FETCH;
            S_R_EXEC:    w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // Moore output decode of the current state; unlisted signals stay 0.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_source     = 2'b00;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_alu_src_b = 2'b01;
                w_pc_write  = 1'b1;
            end
            S_DECODE:    w_alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEM_WB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_R_WB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_ADDI_WB:   w_reg_write = 1'b1;
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
    end

    // Retired-instruction counter: bumps when an enabled edge returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (bus.enable && (w_next == S_FETCH) && (r_state != S_FETCH)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    // Strobes are live only while stepping is enabled and reset is released;
    // combinational so reset kills them without waiting for a clock.
    assign w_gate = bus.enable & ~reset;

    assign bus.pc_en       = (w_pc_write | (w_pc_write_cond & bus.zero)) & w_gate;
    assign bus.ir_write    = w_ir_write  & w_gate;
    assign bus.reg_write   = w_reg_write & w_gate;
    assign bus.mem_write   = w_mem_write & w_gate;
    assign bus.illegal_op  = w_illegal   & w_gate;
    assign bus.pc_source   = w_pc_source;
    assign bus.iord        = w_iord;
    assign bus.mem_read    = w_mem_read;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.alu_op      = w_alu_op;
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its
// expected per-cycle control vectors, and every cycle pops and compares.
module tb_multicycle_control;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct {
        logic [19:0] vec;
        logic [15:0] cnt;
        int          st;
    } ent_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [15:0] exp_cnt;
    ent_t sb_q[$];

    multicycle_control_if #(.CNT_W(16)) bus ();

    multicycle_control #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected control vector for a state, straight from the output table.
    function automatic logic [19:0] exp_vec(input int st, input logic z, input logic g,
                                             input logic ill);
        logic       pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, asa, illo;
        logic [1:0] psrc, asb, aop;
        pc_en = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
        rdst = 1'b0; m2r = 1'b0; rw = 1'b0; asa = 1'b0; illo = 1'b0;
        psrc = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; irw = g; asb = 2'b01; pc_en = g; end
            1:  begin asb = 2'b11; illo = ill & g; end
            2, 10: begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin m2r = 1'b1; rw = g; end
            5:  begin mwr = g; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rdst = 1'b1; rw = g; end
            8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pc_en = z & g; end
            9:  begin pc_en = g; psrc = 2'b10; end
            11: begin rw = g; end
            default: begin pc_en = 1'b0; end
        endcase
        return {4'(st), pc_en, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, illo};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.state, bus.pc_en, bus.pc_source, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.illegal_op};
    endfunction

    task automatic push_exp(input int st, input logic z, input logic g, input logic ill);
        ent_t e;
        e.vec = exp_vec(st, z, g, ill);
        e.cnt = exp_cnt;
        e.st  = st;
        sb_q.push_back(e);
    endtask

    // One cycle: drive enable, compare at the falling edge, then take the rising edge.
    task automatic step(input logic en);
        ent_t e;
        bus.enable = en;
        @(negedge clk);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("ctl_st%0d", e.st), 32'(dut_vec()), 32'(e.vec));
            check($sformatf("cnt_st%0d", e.st), 32'(bus.instr_count), 32'(e.cnt));
        end
        @(posedge clk);
        #1;
    endtask

    // Run one full instruction with enable held high.
    task automatic do_instr(input logic [5:0] op, input logic z);
        int sq[$];
        logic ill;
        ill = 1'b0;
        case (op)
            OP_LW:    sq = '{0, 1, 2, 3, 4};
            OP_SW:    sq = '{0, 1, 2, 5};
            OP_RTYPE: sq = '{0, 1, 6, 7};
            OP_BEQ:   sq = '{0, 1, 8};
            OP_J:     sq = '{0, 1, 9};
            OP_ADDI:  sq = '{0, 1, 10, 11};
            default: begin sq = '{0, 1}; ill = 1'b1; end
        endcase
        bus.opcode = op;
        bus.zero   = z;
        foreach (sq[i]) push_exp(sq[i], z, 1'b1, ill);
        exp_cnt = exp_cnt + 16'd1;
        foreach (sq[i]) step(1'b1);
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        exp_cnt    = 16'd0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        #3;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);
        check("rst_strobes", 32'({bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_instr(OP_LW, 1'b0);
        do_instr(OP_SW, 1'b0);
        do_instr(OP_BEQ, 1'b1);
        do_instr(OP_BEQ, 1'b0);
        do_instr(OP_BAD, 1'b0);
        do_instr(OP_RTYPE, 1'b0);
        do_instr(OP_J, 1'b0);
        do_instr(OP_ADDI, 1'b1);

        // R-type with enable dropped for three edges in R_WB.
        bus.opcode = OP_RTYPE;
        bus.zero   = 1'b0;
        push_exp(0, 1'b0, 1'b1, 1'b0);
        push_exp(1, 1'b0, 1'b1, 1'b0);
        push_exp(6, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 3; i++) push_exp(7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0);
        push_exp(7, 1'b0, 1'b1, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        step(1'b1);

        // lw interrupted by reset in MEM_READ.
        bus.opcode = OP_LW;
        push_exp(0, 1'b0, 1'b1, 1'b0);
        push_exp(1, 1'b0, 1'b1, 1'b0);
        push_exp(2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("pre_rst_state", 32'(bus.state), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_state", 32'(bus.state), 32'd0);
        check("async_rst_count", 32'(bus.instr_count), 32'd0);
        check("async_rst_strobes",
              32'({bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write}), 32'd0);
        exp_cnt = 16'd0;
        push_exp(0, 1'b0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        step(1'b1);
        reset = 1'b0;

        do_instr(OP_ADDI, 1'b0);
        check("final_count", 32'(bus.instr_count), 32'(exp_cnt));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
